// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and the
// data-memory stage, with data priority, a fetch starvation guard and timeout abort.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_done,
  output logic [63:0] dm_rdata,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  starve_cnt;
  logic [7:0]  wait_cnt;
  logic        squash;
  logic        if_elig;
  logic        dm_elig;
  logic        grant_if;
  logic        grant_dm;
  logic        if_lost;
  logic        ack_end;
  logic        abort;
  logic        kill_if;

  // A requester whose done is showing still holds a stale req this cycle.
  assign if_elig = if_req & ~if_flush & ~if_done;
  assign dm_elig = dm_req & ~dm_done;
  assign kill_if = squash | if_flush;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = dm_req & ~dm_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    if_lost   = 1'b0;
    ack_end   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (dm_elig && !(if_elig && starve_cnt == STARVE_MAX)) begin
          grant_dm  = 1'b1;
          if_lost   = if_elig;
          state_nxt = BUSY_DM;
        end else if (if_elig) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          ack_end   = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      wait_cnt   <= '0;
      squash     <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= NOP;
      dm_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      err     <= 1'b0;

      if (grant_if)
        starve_cnt <= '0;
      else if (if_lost && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;

      if (grant_if || grant_dm) begin
        mem_valid <= 1'b1;
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
        wait_cnt  <= '0;
        squash    <= 1'b0;
      end else if (ack_end || abort) begin
        mem_valid <= 1'b0;
        mem_we    <= 1'b0;
        squash    <= 1'b0;
        err       <= abort;
        if (state == BUSY_IF) begin
          // A flushed fetch still occupies memory but delivers nothing.
          if (!kill_if) begin
            if_done  <= 1'b1;
            if_rdata <= abort ? NOP : mem_rdata[31:0];
          end
        end else begin
          dm_done <= 1'b1;
          if (abort)        dm_rdata <= '0;
          else if (!mem_we) dm_rdata <= mem_rdata;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (state == BUSY_IF && if_flush) squash <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model with
// cycle-stamped timeouts, protocol-following requesters and a random memory.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;
  localparam int NCYC         = 4000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NONE = 0, OWN_IF = 1, OWN_DM = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [63:0] dm_addr = '0;
  logic [63:0] dm_wdata = '0;
  logic        dm_done;
  logic [63:0] dm_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: who owns the memory, since which cycle, and the
  // values the outputs are expected to show.
  int          owner;
  int          losses;
  int          start_cyc;
  bit          squash;
  logic        e_if_done, e_dm_done, e_err;
  logic        e_mem_valid, e_mem_we;
  logic [63:0] e_mem_addr, e_mem_wdata, e_dm_rdata;
  logic [31:0] e_if_rdata;
  bit          if_drop = 0;
  bit          dm_drop = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = NONE; losses = 0; start_cyc = 0; squash = 0;
    e_if_done = 0; e_dm_done = 0; e_err = 0;
    e_mem_valid = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
    e_if_rdata = NOP; e_dm_rdata = '0;
  endtask

  task automatic give(input int who);
    owner = who;
    start_cyc = cyc + 1;
    squash = 0;
    e_mem_valid = 1;
    if (who == OWN_IF) begin
      losses = 0;
      e_mem_we = 0; e_mem_addr = if_addr; e_mem_wdata = '0;
    end else begin
      e_mem_we = dm_we; e_mem_addr = dm_addr; e_mem_wdata = dm_wdata;
    end
  endtask

  task automatic model_step();
    bit pif, pdm, want_if, want_dm, kill, ab;
    pif = e_if_done;
    pdm = e_dm_done;
    e_if_done = 0; e_dm_done = 0; e_err = 0;
    if (owner == NONE) begin
      want_if = if_req && !if_flush && !pif;
      want_dm = dm_req && !pdm;
      if (want_if && want_dm) begin
        if (losses >= STARVE_LIMIT) give(OWN_IF);
        else begin
          losses = losses + 1;
          give(OWN_DM);
        end
      end else if (want_dm) give(OWN_DM);
      else if (want_if) give(OWN_IF);
    end else begin
      kill = squash || if_flush;
      if (mem_ack || (cyc - start_cyc + 1) == TIMEOUT) begin
        ab = !mem_ack;
        e_err = ab;
        if (owner == OWN_IF) begin
          if (!kill) begin
            e_if_done = 1;
            e_if_rdata = ab ? NOP : mem_rdata[31:0];
          end
        end else begin
          e_dm_done = 1;
          if (ab) e_dm_rdata = '0;
          else if (!e_mem_we) e_dm_rdata = mem_rdata;
        end
        owner = NONE; squash = 0; e_mem_valid = 0; e_mem_we = 0;
      end else if (owner == OWN_IF && if_flush) begin
        squash = 1;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    chk("mem_valid", mem_valid, e_mem_valid);
    chk("mem_we", mem_we, e_mem_we);
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("if_done", if_done, e_if_done);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("dm_done", dm_done, e_dm_done);
    chk("dm_rdata", dm_rdata, e_dm_rdata);
    chk("err", err, e_err);
  endtask

  task automatic check_stalls();
    chk("stall_if", stall_if, if_req & ~e_if_done);
    chk("stall_mem", stall_mem, dm_req & ~e_dm_done);
  endtask

  task automatic drive(input int c);
    int ph, p_ack, p_if, p_dm;
    ph = (c / 250) % 4;
    case (ph)
      0:       begin p_ack = 60; p_if = 40; p_dm = 30; end
      1:       begin p_ack = 30; p_if = 40; p_dm = 70; end
      2:       begin p_ack = 2;  p_if = 50; p_dm = 30; end
      default: begin p_ack = 80; p_if = 90; p_dm = 90; end
    endcase

    if (if_req && e_if_done) if_drop = 1;
    else if (if_drop) begin
      if_req = 0; if_drop = 0;
    end else if (!if_req && $urandom_range(0, 99) < p_if) begin
      if_req = 1; if_addr = {$urandom, $urandom};
    end

    if (dm_req && e_dm_done) dm_drop = 1;
    else if (dm_drop) begin
      dm_req = 0; dm_drop = 0;
    end else if (!dm_req && $urandom_range(0, 99) < p_dm) begin
      dm_req = 1; dm_we = $urandom_range(0, 1) == 1;
      dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
    end

    if_flush  = $urandom_range(0, 99) < 6;
    mem_ack   = $urandom_range(0, 99) < p_ack;
    mem_rdata = {$urandom, $urandom};
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check_stalls();
    reset = 0;
    for (int c = 0; c < NCYC; c++) begin
      drive(c);
      #1;
      check_stalls();
      if (c % 600 == 300) begin
        #2 reset = 1;
        #1 model_reset();
        check_outputs();
        check_stalls();
        #2 reset = 0;
      end
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
